// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// word size and a ceil-log2 helper used to size the word index.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int WORD_BYTES = 4;

  // Smallest r with 2**r >= value (value >= 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder: DEPTH_WORDS x 32 bits,
// synchronous write and registered read. Contents are never cleared.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int AW          = 7
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Write the addressed word on we_i; capture the addressed word on re_i.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory interface. Accepts one load/store at a
// time over a valid/ready request channel, commits it to the word array after
// WAIT_CYCLES of latency and returns data/ack on a valid/ready response channel.
// Optional build macro DMEM_ALIGN_CHECK_EN: misaligned requests are not
// performed and are answered with rsp_err=1, rsp_rdata=0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW        = clog2(DEPTH_WORDS);
  localparam int         OFS       = clog2(WORD_BYTES);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          req_ready_q;
  logic          write_q;
  logic          mis_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic          accept_s;
  logic          commit_s;
  logic [AW-1:0] req_idx_s;
  logic          req_mis_s;
  logic          cur_write_s;
  logic          cur_mis_s;
  logic [AW-1:0] cur_idx_s;
  logic [31:0]   cur_wdata_s;
  logic          arr_we_s;
  logic          arr_re_s;
  logic [31:0]   arr_rdata_s;
  logic          unused_addr_s;

  assign req_idx_s = req_addr[AW+OFS-1:OFS];
`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis_s = |req_addr[OFS-1:0];
`else
  assign req_mis_s = 1'b0;
`endif
  // Upper address bits wrap; byte-offset bits only matter with the align check.
  assign unused_addr_s = ^{req_addr[31:AW+OFS], req_addr[OFS-1:0]};

  assign accept_s = (state_q == ST_IDLE) && req_valid && req_ready_q;

  // With zero wait the commit happens on the accept edge, before the capture
  // registers are loaded, so the array is fed straight from the request.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_write_s = req_write;
      cur_mis_s   = req_mis_s;
      cur_idx_s   = req_idx_s;
      cur_wdata_s = req_wdata;
    end else begin
      cur_write_s = write_q;
      cur_mis_s   = mis_q;
      cur_idx_s   = idx_q;
      cur_wdata_s = wdata_q;
    end
  end

  // FSM next state, wait counter and response channel next values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    commit_s    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (WAIT_LAST == 4'd0) begin
            state_d  = ST_RESP;
            cnt_d    = 4'd0;
            commit_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'd1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d  = ST_RESP;
          cnt_d    = 4'd0;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        // First RESP cycle: array read data has settled, publish the response.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (write_q || mis_q) ? 32'd0 : arr_rdata_s;
          rsp_err_d   = mis_q;
        end else if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = 4'd0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // A reset on the commit edge cancels the access, so stores stay uncommitted.
  assign arr_we_s = commit_s && !rst && cur_write_s && !cur_mis_s;
  assign arr_re_s = commit_s && !rst && !cur_write_s && !cur_mis_s;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .we_i   (arr_we_s),
    .re_i   (arr_re_s),
    .addr_i (cur_idx_s),
    .wdata_i(cur_wdata_s),
    .rdata_o(arr_rdata_s)
  );

  // State, counter, request capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      write_q     <= 1'b0;
      mis_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept_s) begin
        write_q <= req_write;
        mis_q   <= req_mis_s;
        idx_q   <= req_idx_s;
        wdata_q <= req_wdata;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
